// File: rtl/mmm_defs.sv
// Shared defaults and constant helpers for the Montgomery operand path.
package mmm_defs;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NUM_CH = 4;

    // Number of bits needed to encode value distinct indices.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter: lowest-index priority by default, round-robin with a
// last-served pointer when OPERAND_MUX_RR_EN is defined.
module rr_arbiter
    import mmm_defs::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = clog2(DEF_NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    input  logic              advance,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   index
);

`ifdef OPERAND_MUX_RR_EN
    logic [CH_W-1:0] last_r;

    // Rotating search that starts one past the most recently served channel.
    always_comb begin
        logic            found;
        int              cand;
        logic [CH_W-1:0] cand_idx;
        gnt      = '0;
        index    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = int'(last_r) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end else begin
                cand = cand;
            end
            cand_idx = CH_W'(cand);
            if (en && !found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                index         = cand_idx;
            end else begin
                found = found;
            end
        end
    end

    // The pointer only moves when the granted word is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= CH_W'(NUM_CH - 1);
        end else if (advance) begin
            last_r <= index;
        end else begin
            last_r <= last_r;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{clk, rst_n, advance};

    // Scan from the top down so the lowest requesting index is written last.
    always_comb begin
        gnt   = '0;
        index = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (en && req[k]) begin
                gnt   = NUM_CH'(1) << k;
                index = CH_W'(k);
            end else begin
                gnt   = gnt;
                index = index;
            end
        end
    end
`endif

endmodule

// File: rtl/operand_mux_arb.sv
// N:1 arbitrated operand multiplexer with a 2-entry {channel, data} output buffer.
// Optional feature macro: OPERAND_MUX_RR_EN selects round-robin arbitration.
module operand_mux_arb
    import mmm_defs::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int CH_W   = clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int ENT_W = WIDTH + CH_W;

    logic [1:0]        count_r;
    logic [1:0]        count_nxt_s;
    logic [ENT_W-1:0]  head_r;
    logic [ENT_W-1:0]  tail_r;
    logic              space_s;
    logic              push_s;
    logic              pop_s;
    logic [NUM_CH-1:0] gnt_s;
    logic [CH_W-1:0]   gidx_s;
    logic [ENT_W-1:0]  gent_s;

    // Space comes from the registered count only, so out_ready never reaches in_ready.
    assign space_s = (count_r < 2'd2);

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .en      (space_s & rst_n),
        .advance (push_s),
        .gnt     (gnt_s),
        .index   (gidx_s)
    );

    assign in_ready  = gnt_s;
    assign push_s    = |gnt_s;
    assign pop_s     = out_valid & out_ready;
    assign gent_s    = {gidx_s, in_data[int'(gidx_s) * WIDTH +: WIDTH]};

    assign out_valid = (count_r != 2'd0);
    assign busy      = (count_r != 2'd0);
    assign out_data  = head_r[WIDTH-1:0];
    assign out_ch    = head_r[ENT_W-1:WIDTH];

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + 2'd1;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - 2'd1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Head drives the outputs and holds when empty; tail fills only behind a stalled head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 2'd0;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            count_r <= count_nxt_s;
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        head_r <= gent_s;
                    end else begin
                        head_r <= head_r;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_r <= gent_s;
                    end else if (push_s) begin
                        tail_r <= gent_s;
                    end else begin
                        head_r <= head_r;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_r <= tail_r;
                    end else begin
                        head_r <= head_r;
                    end
                end
                default: begin
                    head_r <= head_r;
                    tail_r <= tail_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_mux_arb.sv
// Self-checking bench for operand_mux_arb: directed scenarios plus randomized
// traffic against a queue-based reference model. Honours OPERAND_MUX_RR_EN.
module tb_operand_mux_arb;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;

    int total = 0;
    int bad   = 0;

    logic [CH_W+WIDTH-1:0] mq[$];
    int                    m_last;

    operand_mux_arb #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        in_data   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reference arbitration: who would be served given the model's occupancy.
    function automatic logic [NUM_CH-1:0] model_grant(input logic [NUM_CH-1:0] v);
        logic [NUM_CH-1:0] g;
        g = '0;
        if (mq.size() < 2) begin
`ifdef OPERAND_MUX_RR_EN
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (m_last + k) % NUM_CH;
                if (v[c] && g == '0) g[c] = 1'b1;
            end
`else
            for (int c = 0; c < NUM_CH; c++) begin
                if (v[c] && g == '0) g[c] = 1'b1;
            end
`endif
        end
        return g;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = 32'hDEADBEEF;
        tick();
        tick();
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b expected 0001", in_ready); end
        in_valid = '0;
        tick();
    endtask

    task automatic test_single();
        in_valid  = 4'b0100;
        in_data   = '0;
        in_data[2*WIDTH +: WIDTH] = 8'hA5;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b expected 0100", in_ready); end
        tick();
        in_valid = '0;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_data: got %h expected a5", out_data); end
        total++; if (out_ch !== 2'd2) begin bad++; $display("FAIL single_ch: got %0d expected 2", out_ch); end
        tick();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        in_data[1*WIDTH +: WIDTH] = 8'h01;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant1: got %b expected 0010", in_ready); end
        tick();
        in_data[1*WIDTH +: WIDTH] = 8'h02;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant2: got %b expected 0010", in_ready); end
        tick();
        in_data[1*WIDTH +: WIDTH] = 8'h03;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_full_block: got %b expected 0000", in_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy: got %b expected 1", busy); end
        tick();
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_no_push_on_pop: got %b expected 0000", in_ready); end
        total++; if (out_data !== 8'h01) begin bad++; $display("FAIL bp_order1: got %h expected 01", out_data); end
        tick();
        #1;
        total++; if (out_data !== 8'h02) begin bad++; $display("FAIL bp_order2: got %h expected 02", out_data); end
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_regrant: got %b expected 0010", in_ready); end
        tick();
        in_valid = '0;
        #1;
        total++; if (out_data !== 8'h03 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_order3: got %h/%b expected 03/1", out_data, out_valid); end
        tick();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        in_data[0 +: WIDTH] = 8'hAA;
        tick();
        in_data[0 +: WIDTH] = 8'hBB;
        tick();
        in_valid  = 4'b1000;
        in_data[3*WIDTH +: WIDTH] = 8'hCC;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL fullpop_block: got %b expected 0000", in_ready); end
        total++; if (out_data !== 8'hAA) begin bad++; $display("FAIL fullpop_head: got %h expected aa", out_data); end
        tick();
        #1;
        total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL fullpop_push_next: got %b expected 1000", in_ready); end
        total++; if (out_data !== 8'hBB) begin bad++; $display("FAIL fullpop_second: got %h expected bb", out_data); end
        tick();
        in_valid = '0;
        #1;
        total++; if (out_data !== 8'hCC || out_ch !== 2'd3) begin bad++; $display("FAIL fullpop_third: got %h/%0d expected cc/3", out_data, out_ch); end
        tick();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fullpop_count: got %b expected 0", out_valid); end
    endtask

    task automatic test_arbitration();
        logic [NUM_CH-1:0] exp_g;
        int                prev_ch;
        apply_reset();
        out_ready = 1'b1;
        in_valid  = '1;
        for (int c = 0; c < NUM_CH; c++) in_data[c*WIDTH +: WIDTH] = 8'(8'h10 + c);
        prev_ch = -1;
        for (int k = 0; k < 8; k++) begin
            #1;
`ifdef OPERAND_MUX_RR_EN
            exp_g = NUM_CH'(1) << (k % NUM_CH);
`else
            exp_g = 4'b0001;
`endif
            total++; if (in_ready !== exp_g) begin bad++; $display("FAIL arb_grant[%0d]: got %b expected %b", k, in_ready, exp_g); end
            if (prev_ch >= 0) begin
                total++;
                if (out_valid !== 1'b1 || out_ch !== CH_W'(prev_ch) || out_data !== 8'(8'h10 + prev_ch)) begin
                    bad++; $display("FAIL arb_out[%0d]: got %b/%0d/%h expected 1/%0d/%h", k, out_valid, out_ch, out_data, prev_ch, 8'(8'h10 + prev_ch));
                end
            end
            prev_ch = 0;
            for (int c = 0; c < NUM_CH; c++) if (exp_g[c]) prev_ch = c;
            tick();
        end
        in_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        in_data[2*WIDTH +: WIDTH] = 8'h11;
        tick();
        in_data[2*WIDTH +: WIDTH] = 8'h22;
        tick();
        in_valid = 4'b1111;
        rst_n    = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL midrst_ready: got %b expected 0000", in_ready); end
        tick();
        rst_n     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale[%0d]: got %b/%h expected 0", k, out_valid, out_data); end
            tick();
        end
        in_valid = 4'b0010;
        in_data[1*WIDTH +: WIDTH] = 8'h33;
        tick();
        in_valid = '0;
        #1;
        total++; if (out_data !== 8'h33 || out_ch !== 2'd1) begin bad++; $display("FAIL midrst_fresh: got %h/%0d expected 33/1", out_data, out_ch); end
        tick();
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] exp_g;
        apply_reset();
        mq.delete();
        m_last = NUM_CH - 1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!in_valid[c]) begin
                    in_valid[c] = ($urandom_range(0, 2) != 0);
                    in_data[c*WIDTH +: WIDTH] = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_g = model_grant(in_valid);
            total++; if (in_ready !== exp_g) begin bad++; $display("FAIL rnd_grant[%0d]: got %b expected %b", cyc, in_ready, exp_g); end
            total++; if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d]: got %b expected %0d", cyc, out_valid, mq.size() != 0); end
            total++; if (busy !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_busy[%0d]: got %b expected %0d", cyc, busy, mq.size() != 0); end
            if (mq.size() != 0) begin
                total++;
                if ({out_ch, out_data} !== mq[0]) begin bad++; $display("FAIL rnd_head[%0d]: got %0d/%h expected %0d/%h", cyc, out_ch, out_data, mq[0][CH_W+WIDTH-1:WIDTH], mq[0][WIDTH-1:0]); end
            end
            @(posedge clk);
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            for (int c = 0; c < NUM_CH; c++) begin
                if (exp_g[c]) begin
                    mq.push_back({CH_W'(c), in_data[c*WIDTH +: WIDTH]});
                    m_last = c;
                end
            end
            @(negedge clk);
            in_valid = in_valid & ~exp_g;
        end
        in_valid = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_full_pop();
        test_arbitration();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_mux_arb.md
# operand_mux_arb

Parametrised N:1 registered operand multiplexer with per-channel valid/ready handshake, arbitration and a 2-entry output buffer. It replaces the combinational 2:1 select feeding the Montgomery datapath, so several producers can share one WIDTH-bit operand bus: operand registers, precomputed multiples and the conditional-subtract result. Each accepted word is tagged with its source channel and delivered in order on a single valid/ready output.

## Interface
- WIDTH, 8: data width per channel, ≥1
- NUM_CH, 4: number of input channels, ≥2
- CH_W, $clog2(NUM_CH): channel-id width (derived, do not override)
- clk  in  1  rising-edge clock; the single clock domain
- rst_n  in  1  asynchronous active-low reset
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NUM_CH  channel i offers a word
- in_ready  out  NUM_CH  one-hot grant; channel i's word is accepted this cycle
- out_data  out  WIDTH  head-of-buffer word
- out_ch  out  CH_W  source channel of out_data
- out_valid  out  1  buffer non-empty
- out_ready  in  1  consumer accepts head
- busy  out  1  buffer count ≠ 0

## Operation
- Buffer: 2-entry FIFO (count 0..2) holding {ch, data}.
- space = (count < 2), computed from registered count only, so no combinational path runs from out_ready to in_ready.
- Grant: if space, exactly one valid channel is selected and in_ready is one-hot on it. Otherwise in_ready = 0.
- Push: in_valid[g] & in_ready[g]. Pop: out_valid & out_ready.
- Simultaneous push and pop: count unchanged. At count = 2 no push occurs even if a pop happens that cycle.
- Selection without the macro: lowest-index valid channel.
- Selection with the macro: round-robin. Search starts at last+1 and wraps at NUM_CH-1 → 0. last updates to g only on a push.
- in_data on non-granted channels is ignored. A producer holds in_valid and in_data stable until accepted.
- Output stability: while out_valid & ~out_ready, out_data and out_ch hold.
- No arithmetic other than count ±1 and pointer wrap. Data passes unmodified.

## Timing
- Reset (async assert, sync release): count = 0, out_valid = 0, out_data = 0, out_ch = 0, busy = 0, in_ready = 0, last = NUM_CH-1, so channel 0 wins first.
- Latency: a word pushed in cycle t appears on out_valid/out_data at t+1.
- Throughput: 1 word/cycle sustained while out_ready = 1.
- in_ready is combinational from in_valid and registers only.
- Reset asserted mid-transfer: buffered words are discarded, no partial output, and in_ready drops immediately.
- Empty buffer: out_valid = 0 and out_data holds its last value; consumers must not sample it.

## Configuration
- OPERAND_MUX_RR_EN defined: round-robin arbiter with `last` pointer register.
- OPERAND_MUX_RR_EN undefined: fixed priority, lowest index wins. No pointer register is built, and a continuously valid channel 0 may starve the others.

## Structure
- Shared package/header mmm_defs: default WIDTH, NUM_CH, and the clog2 helper used for CH_W.
- Sub-module rr_arbiter (NUM_CH, CH_W): inputs req, en, advance; outputs one-hot gnt and index. It contains the priority or round-robin logic under OPERAND_MUX_RR_EN.
- Top level: the arbiter, a WIDTH+CH_W wide 2-entry FIFO, and the count logic.

## Test plan
- Reset: hold rst_n = 0 with in_valid = 4'b1111 → in_ready = 0, out_valid = 0, out_data = 0, out_ch = 0. After release, the first grant is channel 0.
- Single channel: ch2 offers 8'hA5 with out_ready = 1 → in_ready = 4'b0100 in cycle t; out_data = 8'hA5 and out_ch = 2 at t+1.
- Backpressure: out_ready = 0 with ch1 streaming 8'h01, 8'h02, 8'h03 → two pushes, then in_ready = 0 with count = 2. Raising out_ready delivers 01, 02, 03 in order with no loss or duplication.
- Arbitration, all four channels always valid, out_ready = 1:
  - With OPERAND_MUX_RR_EN: grant sequence 0, 1, 2, 3, 0…
  - Without it: grant sequence 0, 0, 0…
- Full with simultaneous pop: count = 2, out_ready = 1, ch3 valid → no push that cycle. The push happens the next cycle, and count goes 2 → 1 → 1.
- Mid-operation reset: assert rst_n low with count = 2 → out_valid = 0 immediately. After release, the old words never appear.
